// File: rtl/memctrl_pkg.sv
// Shared types and helpers for banked_mem_controller: FSM states, regions,
// operations, and the wait-state counter width.
package memctrl_pkg;

    localparam int unsigned WS_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_IO  = 2'd1,
        REG_ROM = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_PUSH  = 2'd2,
        OP_POP   = 2'd3
    } op_t;

    // Anything that is neither RAM nor inside the IO window decodes as ROM,
    // so exactly one region is always selected.
    function automatic region_t region_of(input logic [31:0] addr,
                                          input logic [31:0] ram_top,
                                          input logic [31:0] io_base,
                                          input logic [31:0] io_top);
        region_t r;
        if (addr <= ram_top)
            r = REG_RAM;
        else if (addr >= io_base && addr <= io_top)
            r = REG_IO;
        else
            r = REG_ROM;
        return r;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-to-region decode with per-region wait-state lookup.
module mem_region_decode
    import memctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] RAM_TOP = 'h7FFF,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h8000,
    parameter logic [ADDR_W-1:0] IO_TOP  = 'hBFFF,
    parameter int unsigned       RAM_WS  = 0,
    parameter int unsigned       IO_WS   = 1,
    parameter int unsigned       ROM_WS  = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [WS_W-1:0]   ws
);

    always_comb begin
        region = region_of(32'(addr), 32'(RAM_TOP), 32'(IO_BASE), 32'(IO_TOP));
        ws     = WS_W'(RAM_WS);
        case (region)
            REG_RAM: ws = WS_W'(RAM_WS);
            REG_IO:  ws = WS_W'(IO_WS);
            REG_ROM: ws = WS_W'(ROM_WS);
            default: ws = WS_W'(ROM_WS);
        endcase
    end

endmodule

// File: rtl/banked_mem_controller.sv
// Banked memory controller: arbitrates CPU and stack requests onto one external bus
// with per-region wait states. Define MEMCTRL_STACK_GUARD_EN to refuse stack over/underflow.
module banked_mem_controller
    import memctrl_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RAM_TOP    = 'h7FFF,
    parameter logic [ADDR_W-1:0] IO_BASE    = 'h8000,
    parameter logic [ADDR_W-1:0] IO_TOP     = 'hBFFF,
    parameter int unsigned       RAM_WS     = 0,
    parameter int unsigned       IO_WS      = 1,
    parameter int unsigned       ROM_WS     = 2,
    parameter logic [ADDR_W-1:0] STACK_BASE = 'h0100,
    parameter logic [7:0]        SP_RESET   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic              stack_push,
    input  logic              stack_pop,
    input  logic [DATA_W-1:0] stack_data_out,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic [DATA_W-1:0] stack_data_in,
    output logic              cpu_ready,
    output logic [7:0]        stack_pointer,
    output logic              stack_err,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_data_out,
    input  logic [DATA_W-1:0] ext_data_in,
    output logic              ext_oe,
    output logic              ext_we,
    output logic              ram_select,
    output logic              io_select,
    output logic              rom_select
);

    state_t            state, state_n;
    op_t               op_q;
    region_t           region_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WS_W-1:0]   cnt_q;
    logic [7:0]        sp;
    logic [7:0]        sp_inc;
    logic              refused_q;

    logic              req_valid;
    op_t               req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    region_t           req_region;
    logic [WS_W-1:0]   req_ws;
    region_t           sel_region;
    logic              is_rd_op;
    logic              is_wr_op;

    assign sp_inc = sp + 8'd1;

    // Fixed priority pop > push > write > read; losers are simply not sampled.
    always_comb begin
        req_valid = 1'b1;
        req_op    = OP_READ;
        req_addr  = cpu_addr;
        req_data  = cpu_data_out;
        if (stack_pop) begin
            req_op   = OP_POP;
            req_addr = STACK_BASE + ADDR_W'(sp_inc);
        end else if (stack_push) begin
            req_op   = OP_PUSH;
            req_addr = STACK_BASE + ADDR_W'(sp);
            req_data = stack_data_out;
        end else if (cpu_mem_write) begin
            req_op = OP_WRITE;
        end else if (cpu_mem_read) begin
            req_op = OP_READ;
        end else begin
            req_valid = 1'b0;
        end
    end

    mem_region_decode #(
        .ADDR_W  (ADDR_W),
        .RAM_TOP (RAM_TOP),
        .IO_BASE (IO_BASE),
        .IO_TOP  (IO_TOP),
        .RAM_WS  (RAM_WS),
        .IO_WS   (IO_WS),
        .ROM_WS  (ROM_WS)
    ) u_req_decode (
        .addr   (req_addr),
        .region (req_region),
        .ws     (req_ws)
    );

`ifdef MEMCTRL_STACK_GUARD_EN
    logic req_refuse;
    logic err_q;

    assign req_refuse = (req_op == OP_PUSH && sp == 8'h00) ||
                        (req_op == OP_POP  && sp == SP_RESET);

    always_ff @(posedge clk) begin
        if (rst) begin
            refused_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && req_valid)
                refused_q <= req_refuse;
            if (state == DONE && refused_q)
                err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    assign refused_q = 1'b0;
    assign stack_err = 1'b0;
`endif

    assign is_rd_op = (op_q == OP_READ)  || (op_q == OP_POP);
    assign is_wr_op = (op_q == OP_WRITE) || (op_q == OP_PUSH);

    always_comb begin
        state_n   = state;
        cpu_ready = 1'b0;
        ext_oe    = 1'b0;
        ext_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_n = ACCESS;
            end
            ACCESS: begin
                ext_oe = is_rd_op && !refused_q;
                if (cnt_q == '0) begin
                    ext_we  = is_wr_op && !refused_q;
                    state_n = DONE;
                end
            end
            DONE: begin
                cpu_ready = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= OP_READ;
            region_q      <= REG_RAM;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            sp            <= SP_RESET;
            cpu_data_in   <= '0;
            stack_data_in <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        region_q <= req_region;
                        addr_q   <= req_addr;
                        wdata_q  <= req_data;
                        cnt_q    <= req_ws;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!refused_q && op_q == OP_READ)
                            cpu_data_in <= ext_data_in;
                        if (!refused_q && op_q == OP_POP)
                            stack_data_in <= ext_data_in;
                    end else begin
                        cnt_q <= cnt_q - WS_W'(1);
                    end
                end
                DONE: begin
                    if (!refused_q && op_q == OP_PUSH)
                        sp <= sp - 8'd1;
                    if (!refused_q && op_q == OP_POP)
                        sp <= sp_inc;
                end
                default: ;
            endcase
        end
    end

    assign stack_pointer = sp;
    assign ext_addr      = addr_q;
    assign ext_data_out  = wdata_q;

    // Idle selects follow the live CPU address; during a transaction they follow the latched one.
    assign sel_region = (state == IDLE)
        ? region_of(32'(cpu_addr), 32'(RAM_TOP), 32'(IO_BASE), 32'(IO_TOP))
        : region_q;
    assign ram_select = (sel_region == REG_RAM);
    assign io_select  = (sel_region == REG_IO);
    assign rom_select = (sel_region == REG_ROM);

endmodule

// File: tb/tb_banked_mem_controller.sv
// Directed self-checking bench for banked_mem_controller with a RAM/IO/ROM board model.
module tb_banked_mem_controller;

    localparam logic [3:0] K_RD   = 4'b0001;
    localparam logic [3:0] K_WR   = 4'b0010;
    localparam logic [3:0] K_PUSH = 4'b0100;
    localparam logic [3:0] K_POP  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_mem_read, cpu_mem_write;
    logic        stack_push, stack_pop;
    logic [7:0]  stack_data_out;
    logic [7:0]  cpu_data_in, stack_data_in;
    logic        cpu_ready;
    logic [7:0]  stack_pointer;
    logic        stack_err;
    logic [15:0] ext_addr;
    logic [7:0]  ext_data_out, ext_data_in;
    logic        ext_oe, ext_we;
    logic        ram_select, io_select, rom_select;

    logic [7:0]  mem [0:65535];
    logic [15:0] rom_off;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat, oe_n, we_n;

    always #5 clk = ~clk;

    banked_mem_controller #(
        .DATA_W     (8),
        .ADDR_W     (16),
        .RAM_TOP    (16'h7FFF),
        .IO_BASE    (16'h8000),
        .IO_TOP     (16'hBFFF),
        .RAM_WS     (0),
        .IO_WS      (1),
        .ROM_WS     (2),
        .STACK_BASE (16'h0100),
        .SP_RESET   (8'hFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_data_out   (cpu_data_out),
        .cpu_mem_read   (cpu_mem_read),
        .cpu_mem_write  (cpu_mem_write),
        .stack_push     (stack_push),
        .stack_pop      (stack_pop),
        .stack_data_out (stack_data_out),
        .cpu_data_in    (cpu_data_in),
        .stack_data_in  (stack_data_in),
        .cpu_ready      (cpu_ready),
        .stack_pointer  (stack_pointer),
        .stack_err      (stack_err),
        .ext_addr       (ext_addr),
        .ext_data_out   (ext_data_out),
        .ext_data_in    (ext_data_in),
        .ext_oe         (ext_oe),
        .ext_we         (ext_we),
        .ram_select     (ram_select),
        .io_select      (io_select),
        .rom_select     (rom_select)
    );

    // Board model: writable RAM/IO below 0xC000, ROM returns 0xA5 + offset.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (ext_we && ext_addr < 16'hC000)
                mem[ext_addr] <= ext_data_out;
        end
    end

    assign rom_off     = ext_addr - 16'hC000;
    assign ext_data_in = (ext_addr >= 16'hC000) ? 8'(16'h00A5 + rom_off) : mem[ext_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises the requested lines, lets the next edge sample them, counts cycles to cpu_ready
    // (cycle 1 is the one right after sampling), then drops requests and returns in IDLE.
    task automatic xact(input logic [3:0] kind, input logic [15:0] addr, input logic [7:0] wd,
                        output int l, output int oe_c, output int we_c);
        cpu_addr       = addr;
        cpu_data_out   = wd;
        stack_data_out = wd;
        cpu_mem_read   = kind[0];
        cpu_mem_write  = kind[1];
        stack_push     = kind[2];
        stack_pop      = kind[3];
        oe_c = 0;
        we_c = 0;
        tick();
        l = 1;
        while (!cpu_ready && l < 40) begin
            if (ext_oe) oe_c++;
            if (ext_we) we_c++;
            tick();
            l++;
        end
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        stack_push    = 1'b0;
        stack_pop     = 1'b0;
        check("ready_seen", 32'(cpu_ready), 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = 16'h0000;
        cpu_data_out = 8'h00;
        stack_data_out = 8'h00;
        cpu_mem_read = 1'b0;
        cpu_mem_write = 1'b0;
        stack_push = 1'b0;
        stack_pop = 1'b0;
        tick();
        tick();

        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_oe", 32'(ext_oe), 32'd0);
        check("rst_we", 32'(ext_we), 32'd0);
        check("rst_sp", 32'(stack_pointer), 32'hFF);
        check("rst_err", 32'(stack_err), 32'd0);
        check("rst_cdin", 32'(cpu_data_in), 32'h00);
        check("rst_sdin", 32'(stack_data_in), 32'h00);
        check("rst_eaddr", 32'(ext_addr), 32'h0000);
        check("rst_edout", 32'(ext_data_out), 32'h00);
        check("rst_sel", 32'({ram_select, io_select, rom_select}), 32'b100);
        rst = 1'b0;
        tick();

        // RAM write then read back, WS=0
        xact(K_WR, 16'h0200, 8'h42, lat, oe_n, we_n);
        check("ramwr_lat", 32'(lat), 32'd2);
        check("ramwr_we", 32'(we_n), 32'd1);
        check("ramwr_mem", 32'(mem[16'h0200]), 32'h42);
        xact(K_RD, 16'h0200, 8'h00, lat, oe_n, we_n);
        check("ramrd_lat", 32'(lat), 32'd2);
        check("ramrd_oe", 32'(oe_n), 32'd1);
        check("ramrd_data", 32'(cpu_data_in), 32'h42);

        // ROM read, WS=2
        cpu_addr = 16'hC010;
        #1;
        check("rom_sel", 32'({ram_select, io_select, rom_select}), 32'b001);
        xact(K_RD, 16'hC010, 8'h00, lat, oe_n, we_n);
        check("romrd_lat", 32'(lat), 32'd4);
        check("romrd_oe", 32'(oe_n), 32'd3);
        check("romrd_data", 32'(cpu_data_in), 32'hB5);

        // IO write, WS=1
        cpu_addr = 16'h8004;
        #1;
        check("io_sel", 32'({ram_select, io_select, rom_select}), 32'b010);
        xact(K_WR, 16'h8004, 8'h33, lat, oe_n, we_n);
        check("iowr_lat", 32'(lat), 32'd3);
        check("iowr_we", 32'(we_n), 32'd1);
        check("iowr_mem", 32'(mem[16'h8004]), 32'h33);
        check("iowr_keep_cdin", 32'(cpu_data_in), 32'hB5);

        // Stack push/pop
        xact(K_PUSH, 16'h0000, 8'h55, lat, oe_n, we_n);
        check("push1_lat", 32'(lat), 32'd2);
        check("push1_sp", 32'(stack_pointer), 32'hFE);
        check("push1_mem", 32'(mem[16'h01FF]), 32'h55);
        xact(K_PUSH, 16'h0000, 8'hAA, lat, oe_n, we_n);
        check("push2_sp", 32'(stack_pointer), 32'hFD);
        check("push2_mem", 32'(mem[16'h01FE]), 32'hAA);
        xact(K_POP, 16'h0000, 8'h00, lat, oe_n, we_n);
        check("pop1_data", 32'(stack_data_in), 32'hAA);
        check("pop1_sp", 32'(stack_pointer), 32'hFE);
        xact(K_POP, 16'h0000, 8'h00, lat, oe_n, we_n);
        check("pop2_data", 32'(stack_data_in), 32'h55);
        check("pop2_sp", 32'(stack_pointer), 32'hFF);

        // Pop beats a simultaneous write
        xact(K_PUSH, 16'h0000, 8'h11, lat, oe_n, we_n);
        check("push3_sp", 32'(stack_pointer), 32'hFE);
        xact(K_POP | K_WR, 16'h0300, 8'h99, lat, oe_n, we_n);
        check("prio_we", 32'(we_n), 32'd0);
        check("prio_mem", 32'(mem[16'h0300]), 32'h00);
        check("prio_data", 32'(stack_data_in), 32'h11);
        check("prio_sp", 32'(stack_pointer), 32'hFF);

        // Pop at the reset SP value
        xact(K_POP, 16'h0000, 8'h00, lat, oe_n, we_n);
        check("pop_ff_lat", 32'(lat), 32'd2);
`ifdef MEMCTRL_STACK_GUARD_EN
        check("guard_err", 32'(stack_err), 32'd1);
        check("guard_sp", 32'(stack_pointer), 32'hFF);
        check("guard_oe", 32'(oe_n), 32'd0);
        check("guard_keep", 32'(stack_data_in), 32'h11);
`else
        check("wrap_err", 32'(stack_err), 32'd0);
        check("wrap_sp", 32'(stack_pointer), 32'h00);
        check("wrap_oe", 32'(oe_n), 32'd1);
        check("wrap_data", 32'(stack_data_in), 32'h00);
        xact(K_PUSH, 16'h0000, 8'h66, lat, oe_n, we_n);
        check("wrap_push_sp", 32'(stack_pointer), 32'hFF);
        check("wrap_push_mem", 32'(mem[16'h0100]), 32'h66);
`endif

        // Reset during ACCESS aborts the IO write
        cpu_addr = 16'h9000;
        cpu_data_out = 8'h77;
        cpu_mem_write = 1'b1;
        tick();
        check("abort_we_pre", 32'(ext_we), 32'd0);
        rst = 1'b1;
        tick();
        cpu_mem_write = 1'b0;
        check("abort_we", 32'(ext_we), 32'd0);
        check("abort_ready", 32'(cpu_ready), 32'd0);
        check("abort_mem", 32'(mem[16'h9000]), 32'h00);
        check("abort_eaddr", 32'(ext_addr), 32'h0000);
        check("abort_edout", 32'(ext_data_out), 32'h00);
        check("abort_cdin", 32'(cpu_data_in), 32'h00);
        check("abort_sdin", 32'(stack_data_in), 32'h00);
        check("abort_sp", 32'(stack_pointer), 32'hFF);
        check("abort_err", 32'(stack_err), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("abort_no_ready", 32'(cpu_ready), 32'd0);
        check("abort_mem_late", 32'(mem[16'h9000]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
